// File: rtl/face_frame_sequencer.sv
// face_frame_sequencer
//   Frame-level controller between the camera stream and the face detection
//   datapath. Accepts camera beats, aligns them to SOF/EOL and forwards pixels
//   to the detector one cycle after acceptance. It tracks the x/y position
//   within the frame. At end of frame it waits for the detector pipeline to
//   drain, then latches the detector box into stable result registers and
//   pulses frame_done. Line-length and framing errors set a sticky flag.
//
//   Optional build macro FACE_SEQ_FRAME_SKIP_EN: only every SKIP_DIV-th frame
//   is forwarded and reported. The other frames are consumed silently.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      start / continue frame processing
//   cam_valid/sof/eol/pixel     camera beat in; cam_ready out (transfer = valid & ready)
//   det_pixel/det_valid         registered pixel strobe to the detector
//   det_clear                   one-cycle detector state clear
//   det_face_*                  detector result inputs
//   res_valid/face/x/y/w/h      latched per-frame result
//   frame_done, frame_count     report pulse and wrapping report counter
//   err_line, err_clear         sticky framing error and its clear
//   busy                        sequencer not idle
module face_frame_sequencer #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int FLUSH_CYCLES = 4,
    parameter int SKIP_DIV     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cam_valid,
    input  logic        cam_sof,
    input  logic        cam_eol,
    input  logic [15:0] cam_pixel,
    output logic        cam_ready,
    output logic [15:0] det_pixel,
    output logic        det_valid,
    output logic        det_clear,
    input  logic        det_face_detected,
    input  logic [9:0]  det_face_x,
    input  logic [9:0]  det_face_y,
    input  logic [9:0]  det_face_w,
    input  logic [9:0]  det_face_h,
    output logic        res_valid,
    output logic        res_face,
    output logic [9:0]  res_x,
    output logic [9:0]  res_y,
    output logic [9:0]  res_w,
    output logic [9:0]  res_h,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_line,
    input  logic        err_clear,
    output logic        busy
);
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE, S_FLUSH, S_REPORT} state_t;

    state_t        state, state_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [3:0]    cnt, cnt_n;
    logic          accept, fwd, clr_n, err_set, frame_end, report_entry, fwd_ok;

    assign cam_ready = (state == S_IDLE) || (state == S_WAIT_SOF) || (state == S_ACTIVE);
    assign busy      = (state != S_IDLE);
    assign accept    = cam_valid && cam_ready;

`ifdef FACE_SEQ_FRAME_SKIP_EN
    // Frame phase; only phase-0 frames reach the detector and get reported.
    logic [3:0] phase;
    assign fwd_ok = (phase == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (frame_end)
            phase <= (phase >= 4'(SKIP_DIV - 1)) ? 4'd0 : phase + 4'd1;
    end
`else
    assign fwd_ok = 1'b1;
`endif

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        cnt_n        = cnt;
        fwd          = 1'b0;
        clr_n        = 1'b0;
        err_set      = 1'b0;
        frame_end    = 1'b0;
        report_entry = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_WAIT_SOF;
                    clr_n   = 1'b1;
                end
            end
            S_WAIT_SOF: begin
                if (accept && cam_sof) begin
                    fwd     = fwd_ok;
                    x_n     = XW'(1);
                    y_n     = '0;
                    state_n = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (cam_sof) begin
                        // Unexpected SOF: abandon this frame and resync; the SOF beat is lost.
                        err_set = 1'b1;
                        clr_n   = 1'b1;
                        state_n = S_WAIT_SOF;
                    end else begin
                        fwd = fwd_ok;
                        if (cam_eol != (x == X_LAST))
                            err_set = 1'b1;
                        // Either marker ends the line so we follow the camera's framing.
                        if (cam_eol || (x == X_LAST)) begin
                            x_n = '0;
                            if (y != Y_LAST)
                                y_n = y + 1'b1;
                        end else begin
                            x_n = x + 1'b1;
                        end
                        if ((x == X_LAST) && (y == Y_LAST)) begin
                            frame_end = 1'b1;
                            y_n       = '0;
                            if (fwd_ok) begin
                                state_n = S_FLUSH;
                                cnt_n   = 4'(FLUSH_CYCLES);
                            end else begin
                                // Skipped frame: nothing to drain or report.
                                state_n = enable ? S_WAIT_SOF : S_IDLE;
                            end
                        end
                    end
                end
            end
            S_FLUSH: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n      = S_REPORT;
                    report_entry = 1'b1;
                end
            end
            S_REPORT: begin
                if (enable) begin
                    state_n = S_WAIT_SOF;
                    clr_n   = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            cnt         <= '0;
            det_pixel   <= '0;
            det_valid   <= 1'b0;
            det_clear   <= 1'b0;
            err_line    <= 1'b0;
            res_valid   <= 1'b0;
            res_face    <= 1'b0;
            res_x       <= '0;
            res_y       <= '0;
            res_w       <= '0;
            res_h       <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            cnt        <= cnt_n;
            det_valid  <= fwd;
            if (fwd)
                det_pixel <= cam_pixel;
            det_clear  <= clr_n;
            // A new error in the same cycle as a clear must not be lost.
            err_line   <= err_set | (err_line & ~err_clear);
            frame_done <= report_entry;
            if (report_entry) begin
                res_face    <= det_face_detected;
                res_x       <= det_face_x;
                res_y       <= det_face_y;
                res_w       <= det_face_w;
                res_h       <= det_face_h;
                res_valid   <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/face_frame_sequencer.md
Name: face_frame_sequencer

Overview:
- Frame-level controller placed between the camera stream and the face detection datapath.
- Qualifies camera beats, aligns them to SOF/EOL, and forwards pixels with a 1-cycle registered `det_valid` to the detector.
- Tracks x/y position, drains the detector pipeline at end of frame, then latches the detector result into stable per-frame result registers with a done pulse.
- Flags line-length and framing errors.

Parameters:
- IMG_WIDTH, 640, active pixels per line
- IMG_HEIGHT, 480, active lines per frame
- FLUSH_CYCLES, 4, cycles waited after the last pixel before sampling detector outputs (1..15)
- SKIP_DIV, 2, frame decimation ratio, used only with FRAME_SKIP_EN (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  start/continue frame processing
- cam_valid  in  1  camera beat valid
- cam_sof  in  1  beat is first pixel of frame
- cam_eol  in  1  beat is last pixel of line
- cam_pixel  in  16  RGB565 pixel
- cam_ready  out  1  sequencer accepts beat (beat transfers when cam_valid && cam_ready)
- det_pixel  out  16  pixel to detector
- det_valid  out  1  detector pixel strobe
- det_clear  out  1  one-cycle detector state clear
- det_face_detected  in  1  detector flag
- det_face_x, det_face_y, det_face_w, det_face_h  in  10 each  detector box
- res_valid  out  1  result registers hold a completed frame
- res_face  out  1  latched face flag
- res_x, res_y, res_w, res_h  out  10 each  latched box
- frame_done  out  1  one-cycle pulse per reported frame
- frame_count  out  16  reported frames, wraps at 65535->0
- err_line  out  1  sticky framing error
- err_clear  in  1  clears err_line
- busy  out  1  state is not IDLE

Behaviour:
- Reset values: state IDLE, x=y=0, flush counter 0; all outputs 0 except cam_ready=1.
- cam_ready is a combinational decode of state: 1 in IDLE/WAIT_SOF/ACTIVE, 0 in FLUSH/REPORT.
- busy = (state != IDLE). Beats with cam_valid=0 change nothing.
- IDLE: accepted beats are discarded. enable=1 -> WAIT_SOF; det_clear=1 for the first cycle in WAIT_SOF.
- WAIT_SOF: beats without cam_sof are discarded. An accepted beat with cam_sof:
  - is forwarded as pixel (0,0);
  - sets x=1, y=0;
  - moves to ACTIVE.
- Forwarding: an accepted beat in cycle c gives det_pixel=cam_pixel and det_valid=1 in cycle c+1. det_valid=0 in all other cycles; det_pixel holds its last value.
- ACTIVE, on each accepted beat:
  - cam_eol with x != IMG_WIDTH-1 -> err_line=1; x=0, y+1 (realign to camera).
  - x == IMG_WIDTH-1 without cam_eol -> err_line=1; x=0, y+1 anyway.
  - cam_sof -> err_line=1; beat dropped; frame aborted (not reported); det_clear pulsed; -> WAIT_SOF.
  - Beat at x=IMG_WIDTH-1, y=IMG_HEIGHT-1 -> forwarded; -> FLUSH with counter loaded to FLUSH_CYCLES.
- FLUSH: counter decrements each cycle. At 1 -> REPORT.
- REPORT (exactly 1 cycle):
  - res_* loaded from det_* at the edge entering REPORT;
  - res_valid=1 (held until reset);
  - frame_done=1 during REPORT; frame_count+1.
  - Exit -> WAIT_SOF with det_clear pulse if enable=1, else -> IDLE.
- Latency: last pixel accepted in cycle c0 -> frame_done in cycle c0+FLUSH_CYCLES+1.
- enable dropped mid-frame: current frame completes and is reported, then -> IDLE.
- err_line:
  - sticky; cleared by err_clear;
  - if set and clear occur in the same cycle, set wins.
- y wrap: y increments only within the frame. The end-of-frame beat always exits ACTIVE, so y never exceeds IMG_HEIGHT-1.
- Async reset mid-frame: immediate return to reset values. res_valid=0, so the previous result is lost.

Optional Feature:
- Macro FACE_SEQ_FRAME_SKIP_EN.
- When defined, a frame phase counter (0..SKIP_DIV-1) advances at every frame end, including skipped frames.
  - Only phase-0 frames are forwarded and reported.
  - Skipped frames are consumed through WAIT_SOF/ACTIVE with det_valid held 0.
  - Skipped frames produce no FLUSH, REPORT, frame_done or frame_count change, and go straight back to WAIT_SOF.
  - Framing errors are still flagged.
- When undefined, every frame is processed and the phase counter is absent.

Test Plan:
- All tests use IMG_WIDTH=8, IMG_HEIGHT=4, FLUSH_CYCLES=4.
- Reset check: during and after reset -> all outputs 0 and cam_ready=1. With enable=1 and a 32-beat frame (SOF on beat 0, EOL every 8th), det_face_detected=1, x=5, y=3, w=6, h=6 -> 32 det_valid pulses, each 1 cycle after its beat; frame_done at last-beat cycle+5; res_face=1 with res_x=5, res_y=3, res_w=6, res_h=6; frame_count=1.
- Pre-SOF garbage: 3 beats without SOF, then a valid frame -> 3 beats dropped with no det_valid; the frame is reported normally.
- Short line: EOL on x=5 of line 1 -> err_line=1, next beat at x=0, y=2. err_clear -> err_line=0 next cycle.
- Mid-frame SOF at beat 12 -> err_line=1, det_clear pulse, no frame_done. A following clean frame gives frame_done and frame_count=1.
- Back-pressure and enable: cam_valid held high across a frame boundary -> cam_ready=0 for 5 cycles (FLUSH+REPORT) and no beats lost. enable dropped at beat 10 -> the frame completes, frame_done fires, then busy=0.
- With FACE_SEQ_FRAME_SKIP_EN and SKIP_DIV=2: 4 consecutive frames -> frame_done for frames 0 and 2 only, frame_count=2, no det_valid during frames 1 and 3.
